// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-port 16-bit data memory (round-robin, bounded bursts).
// Latency: grant 1 cycle after req from IDLE; read data/rvalid registered 1 cycle after gnt.
// Backpressure: a request holds until gnt; a non-owner waits for the owner to release or hit MAX_BURST.
module dmem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid1,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_BURST);
    localparam logic [CNT_W:0]   BURST_LIM = (CNT_W + 1)'(MAX_BURST);
    localparam logic [CNT_W:0]   ONE       = (CNT_W + 1)'(1);

    logic [1:0]       state, state_nxt;
    logic             rr_last, rr_nxt;
    logic [CNT_W-1:0] burst_cnt, cnt_nxt;
    logic [CNT_W:0]   cnt_inc;
    logic             burst_done;
    logic             own_req, oth_req;
    logic [1:0]       oth_state;

    assign gnt0 = (state == OWN0) && req0;
    assign gnt1 = (state == OWN1) && req1;

    always_comb begin
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        if (gnt0) begin
            mem_access_addr = addr0;
            mem_write_data  = wdata0;
            mem_write_en    = we0;
            mem_read        = ~we0;
        end else if (gnt1) begin
            mem_access_addr = addr1;
            mem_write_data  = wdata1;
            mem_write_en    = we1;
            mem_read        = ~we1;
        end
    end

    assign own_req    = (state == OWN0) ? req0 : req1;
    assign oth_req    = (state == OWN0) ? req1 : req0;
    assign oth_state  = (state == OWN0) ? OWN1 : OWN0;
    assign cnt_inc    = {1'b0, burst_cnt} + ONE;
    // >= so a counter saturated during an uncontested run still forces a handover.
    assign burst_done = (cnt_inc >= BURST_LIM);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = burst_cnt;
        rr_nxt    = rr_last;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || rr_last)) state_nxt = OWN0;
                else if (req1)                  state_nxt = OWN1;
            end
            OWN0, OWN1: begin
                if (!own_req) begin
                    cnt_nxt   = '0;
                    state_nxt = oth_req ? oth_state : IDLE;
                end else begin
                    rr_nxt = (state == OWN1);
                    if (oth_req && burst_done) begin
                        state_nxt = oth_state;
                        cnt_nxt   = '0;
                    end else if (burst_cnt != MAX_CNT) begin
                        cnt_nxt = cnt_inc[CNT_W-1:0];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_last   <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            rr_last   <= rr_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= gnt0 && !we0;
            rvalid1 <= gnt1 && !we1;
            if (gnt0 && !we0) rdata0 <= mem_read_data;
            if (gnt1 && !we1) rdata1 <= mem_read_data;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural memory, reference memory and read-data scoreboard.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
    logic        mem_write_en, mem_read;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];
    logic        init_done = 1'b0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] last0, last1;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read(mem_read),
        .mem_read_data(mem_read_data)
    );

    // Memory preload: word i holds i>>3, so word 0x10 (byte 0x0020) reads 0x0002.
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'(i >> 3);
            init_done <= 1'b1;
        end else if (mem_write_en) begin
            mem[mem_access_addr[8:1]] <= mem_write_data;
        end
    end
    assign mem_read_data = mem[mem_access_addr[8:1]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs were just driven at a negedge; check this cycle's grant and pins,
    // update the model, then check the registered outputs at the next negedge.
    task automatic go(input logic eg0, input logic eg1);
        logic p0, p1;
        logic [15:0] e;
        #1;
        chk("gnt0", gnt0, eg0);
        chk("gnt1", gnt1, eg1);
        if (eg0) begin
            chk("pin_addr0", mem_access_addr, addr0);
            chk("pin_we0", mem_write_en, we0);
            chk("pin_rd0", mem_read, !we0);
            if (we0) chk("pin_wd0", mem_write_data, wdata0);
        end else if (eg1) begin
            chk("pin_addr1", mem_access_addr, addr1);
            chk("pin_we1", mem_write_en, we1);
            chk("pin_rd1", mem_read, !we1);
            if (we1) chk("pin_wd1", mem_write_data, wdata1);
        end else begin
            chk("pin_idle_we", mem_write_en, 1'b0);
            chk("pin_idle_rd", mem_read, 1'b0);
            chk("pin_idle_addr", mem_access_addr, 16'h0000);
        end
        p0 = eg0 && !we0;
        p1 = eg1 && !we1;
        if (p0) q0.push_back(ref_mem[addr0[8:1]]);
        if (p1) q1.push_back(ref_mem[addr1[8:1]]);
        if (eg0 && we0) ref_mem[addr0[8:1]] = wdata0;
        if (eg1 && we1) ref_mem[addr1[8:1]] = wdata1;
        @(negedge clk);
        chk("rvalid0", rvalid0, p0);
        chk("rvalid1", rvalid1, p1);
        if (p0) begin
            e = (q0.size() > 0) ? q0.pop_front() : 16'hxxxx;
            chk("rdata0", rdata0, e);
            last0 = e;
        end else chk("rdata0_hold", rdata0, last0);
        if (p1) begin
            e = (q1.size() > 0) ? q1.pop_front() : 16'hxxxx;
            chk("rdata1", rdata1, e);
            last1 = e;
        end else chk("rdata1_hold", rdata1, last1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i >> 3);
        last0 = 16'h0000;
        last1 = 16'h0000;
        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010; wdata0 = 16'h0000;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0100; wdata1 = 16'h0000;

        // Reset held with both requests high
        repeat (3) @(negedge clk);
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_gnt1", gnt1, 1'b0);
        chk("rst_rvalid0", rvalid0, 1'b0);
        chk("rst_rvalid1", rvalid1, 1'b0);
        chk("rst_we", mem_write_en, 1'b0);
        chk("rst_rd", mem_read, 1'b0);
        chk("rst_rdata0", rdata0, 16'h0000);
        rst_n = 1'b1;
        go(1'b0, 1'b0);
        go(1'b1, 1'b0);   // port 0 wins the first tie
        req0 = 1'b0; req1 = 1'b0;
        go(1'b0, 1'b0);

        // Single port: write 0xBEEF, read it back, read unwritten word
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wdata0 = 16'hBEEF;
        go(1'b0, 1'b0);
        go(1'b1, 1'b0);
        we0 = 1'b0;
        go(1'b1, 1'b0);
        chk("beef_const", rdata0, 16'hBEEF);
        addr0 = 16'h0020;
        go(1'b1, 1'b0);
        chk("unwritten_const", rdata0, 16'h0002);
        req0 = 1'b0;
        go(1'b0, 1'b0);

        // Early release by port 1, then sustained contention
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0100;
        go(1'b0, 1'b0);
        go(1'b0, 1'b1);
        req0 = 1'b1; addr0 = 16'h0010;
        go(1'b0, 1'b1);
        req1 = 1'b0;
        go(1'b0, 1'b0);
        req1 = 1'b1;
        repeat (4) go(1'b1, 1'b0);
        repeat (4) go(1'b0, 1'b1);
        repeat (4) go(1'b1, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        go(1'b0, 1'b0);

        // Uncontested port 1 write run, then port 0 arrives
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0030;
        go(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            wdata1 = 16'h1000 + 16'(i);
            go(1'b0, 1'b1);
        end
        wdata1 = 16'h100A;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0030;
        go(1'b0, 1'b1);
        req1 = 1'b0; we1 = 1'b0;
        go(1'b1, 1'b0);
        chk("last_write_const", rdata0, 16'h100A);
        req0 = 1'b0;
        go(1'b0, 1'b0);

        // Reset during a port 1 read grant
        req1 = 1'b1; addr1 = 16'h0100;
        go(1'b0, 1'b0);
        #1;
        chk("mid_gnt1", gnt1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_gnt1_rst", gnt1, 1'b0);
        chk("mid_rd_rst", mem_read, 1'b0);
        @(negedge clk);
        chk("mid_rvalid1", rvalid1, 1'b0);
        chk("mid_rdata1", rdata1, 16'h0000);
        chk("mid_rdata0", rdata0, 16'h0000);
        last0 = 16'h0000;
        last1 = 16'h0000;
        req1 = 1'b0;
        rst_n = 1'b1;
        go(1'b0, 1'b0);
        req0 = 1'b1; req1 = 1'b1; addr0 = 16'h0010;
        go(1'b0, 1'b0);
        go(1'b1, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        go(1'b0, 1'b0);

        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
